// File: rtl/two_ch_splitter_if.sv
// Bundle for the two-channel frame splitter: one input stream, two FIFO write ports and the loss counters.
interface two_ch_splitter_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] DIN;
  logic                  iVALID;
  logic                  oREADY;
  logic [DATA_WIDTH-1:0] CH0_DOUT;
  logic                  CH0_WE;
  logic                  CH0_FULL;
  logic [DATA_WIDTH-1:0] CH1_DOUT;
  logic                  CH1_WE;
  logic                  CH1_FULL;
  logic [15:0]           HEADER_LOST_CNT;
  logic [15:0]           FOOTER_LOST_CNT;

  modport slave (
    input  DIN, iVALID, CH0_FULL, CH1_FULL,
    output oREADY, CH0_DOUT, CH0_WE, CH1_DOUT, CH1_WE, HEADER_LOST_CNT, FOOTER_LOST_CNT
  );

  modport master (
    output DIN, iVALID, CH0_FULL, CH1_FULL,
    input  oREADY, CH0_DOUT, CH0_WE, CH1_DOUT, CH1_WE, HEADER_LOST_CNT, FOOTER_LOST_CNT
  );
endinterface

// File: rtl/two_ch_splitter.sv
// Splits a header/footer framed word stream into two FIFO channels, repairing frames whose footer was lost.
// state      | meaning
// IDLE       | between frames, waiting for a header
// ROUTE      | inside a frame, words go to cur_ch
// FIX_FOOTER | synthesized footer sent, held header waits for its channel
module two_ch_splitter #(
  parameter int DATA_WIDTH = 64,
  parameter int CH_BIT     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  two_ch_splitter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUTE, FIX_FOOTER} state_t;

  localparam logic [DATA_WIDTH-1:0] RST_WORD    = {8'h00, {(DATA_WIDTH-8){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] FOOTER_WORD = {4'b1100, {(DATA_WIDTH-12){1'b1}}, 8'hEF};

  state_t                state;
  logic                  cur_ch;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] ch0_dout, ch1_dout;
  logic                  ch0_we, ch1_we;
  logic [15:0]           hdr_lost, ftr_lost;

  logic [1:0]            full;
  logic                  ready, accept, is_hdr, is_ftr, hold_ch;
  logic                  wr, wr_ch;
  logic [DATA_WIDTH-1:0] wr_data;

  assign full    = {bus.CH1_FULL, bus.CH0_FULL};
  assign is_hdr  = &bus.DIN[DATA_WIDTH-1 -: 7];
  assign is_ftr  = !is_hdr && (&bus.DIN[DATA_WIDTH-1 -: 2]) && (bus.DIN[4:0] == 5'b01111);
  assign accept  = bus.iVALID && ready;
  assign hold_ch = hold[CH_BIT];

  always_comb begin
    ready = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE:    ready = !full[0] && !full[1];
        ROUTE:   ready = !full[cur_ch];
        default: ready = 1'b0;
      endcase
    end
  end

  // Single write port shared by both channels; a word is never steered to both.
  always_comb begin
    wr      = 1'b0;
    wr_ch   = cur_ch;
    wr_data = bus.DIN;
    case (state)
      IDLE: begin
        if (accept && is_hdr) begin
          wr    = 1'b1;
          wr_ch = bus.DIN[CH_BIT];
        end
      end
      ROUTE: begin
        if (accept) begin
          wr = 1'b1;
          if (is_hdr) wr_data = FOOTER_WORD;
        end
      end
      FIX_FOOTER: begin
        if (!full[hold_ch]) begin
          wr      = 1'b1;
          wr_ch   = hold_ch;
          wr_data = hold;
        end
      end
      default: wr = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cur_ch   <= 1'b0;
      hold     <= RST_WORD;
      ch0_dout <= RST_WORD;
      ch1_dout <= RST_WORD;
      ch0_we   <= 1'b0;
      ch1_we   <= 1'b0;
      hdr_lost <= 16'd0;
      ftr_lost <= 16'd0;
    end else begin
      ch0_we <= wr && !wr_ch;
      ch1_we <= wr && wr_ch;
      if (wr && !wr_ch) ch0_dout <= wr_data;
      if (wr && wr_ch)  ch1_dout <= wr_data;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_hdr) begin
              cur_ch <= bus.DIN[CH_BIT];
              state  <= ROUTE;
            end else if (hdr_lost != 16'hFFFF) begin
              hdr_lost <= hdr_lost + 16'd1;
            end
          end
        end
        ROUTE: begin
          if (accept) begin
            if (is_hdr) begin
              hold  <= bus.DIN;
              state <= FIX_FOOTER;
              if (ftr_lost != 16'hFFFF) ftr_lost <= ftr_lost + 16'd1;
            end else if (is_ftr) begin
              state <= IDLE;
            end
          end
        end
        FIX_FOOTER: begin
          if (!full[hold_ch]) begin
            cur_ch <= hold_ch;
            state  <= ROUTE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oREADY          = ready;
  assign bus.CH0_DOUT        = ch0_dout;
  assign bus.CH0_WE          = ch0_we;
  assign bus.CH1_DOUT        = ch1_dout;
  assign bus.CH1_WE          = ch1_we;
  assign bus.HEADER_LOST_CNT = hdr_lost;
  assign bus.FOOTER_LOST_CNT = ftr_lost;
endmodule

// File: tb/tb_two_ch_splitter.sv
// Bench for two_ch_splitter: directed frame scenarios plus random traffic against a frame-level reference model.
module tb_two_ch_splitter;
  localparam int DW = 64;
  localparam int CB = 8;
  localparam logic [63:0] RST_WORD = 64'h00FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FOOT     = 64'hCFFF_FFFF_FFFF_FFEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  two_ch_splitter_if #(.DATA_WIDTH(DW)) bus();
  two_ch_splitter #(.DATA_WIDTH(DW), .CH_BIT(CB)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_hdr(input logic [63:0] w);
    return w[63:57] == 7'h7F;
  endfunction

  function automatic bit is_ftr(input logic [63:0] w);
    return !is_hdr(w) && w[63:62] == 2'b11 && w[4:0] == 5'h0F;
  endfunction

  // Reference model: frame-level bookkeeping, expectations for the next cycle.
  bit          m_in_frame, m_pend, m_cur, primed;
  logic [63:0] m_hold;
  int          m_hl, m_fl;
  bit          e_we0, e_we1, exp_rdy, acc;
  logic [63:0] e_d0, e_d1;
  logic [1:0]  fullv;

  function automatic void emit(input bit ch, input logic [63:0] w);
    if (ch) begin e_we1 = 1'b1; e_d1 = w; end
    else    begin e_we0 = 1'b1; e_d0 = w; end
  endfunction

  always @(negedge clk) begin
    if (primed) begin
      check("ch0_we", bus.CH0_WE, e_we0);
      check("ch1_we", bus.CH1_WE, e_we1);
      check("ch0_dout", bus.CH0_DOUT, e_d0);
      check("ch1_dout", bus.CH1_DOUT, e_d1);
      check("hdr_lost_cnt", bus.HEADER_LOST_CNT, 64'(m_hl));
      check("ftr_lost_cnt", bus.FOOTER_LOST_CNT, 64'(m_fl));
    end
    fullv = {bus.CH1_FULL, bus.CH0_FULL};
    if (rst || m_pend)    exp_rdy = 1'b0;
    else if (!m_in_frame) exp_rdy = !fullv[0] && !fullv[1];
    else                  exp_rdy = !fullv[m_cur];
    check("oready", bus.oREADY, exp_rdy);
    e_we0 = 1'b0;
    e_we1 = 1'b0;
    if (rst) begin
      m_in_frame = 0; m_pend = 0; m_cur = 0; m_hold = RST_WORD;
      m_hl = 0; m_fl = 0; e_d0 = RST_WORD; e_d1 = RST_WORD;
    end else if (m_pend) begin
      if (!fullv[m_hold[CB]]) begin
        emit(m_hold[CB], m_hold);
        m_cur = m_hold[CB]; m_pend = 0; m_in_frame = 1;
      end
    end else begin
      acc = bus.iVALID && exp_rdy;
      if (acc) begin
        if (is_hdr(bus.DIN)) begin
          if (m_in_frame) begin
            emit(m_cur, FOOT);
            if (m_fl < 65535) m_fl++;
            m_pend = 1; m_hold = bus.DIN;
          end else begin
            emit(bus.DIN[CB], bus.DIN);
            m_cur = bus.DIN[CB]; m_in_frame = 1;
          end
        end else if (!m_in_frame) begin
          if (m_hl < 65535) m_hl++;
        end else begin
          emit(m_cur, bus.DIN);
          if (is_ftr(bus.DIN)) m_in_frame = 0;
        end
      end
    end
    primed = 1'b1;
  end

  bit rand_full = 1'b0;
  bit f0_req = 1'b0, f1_req = 1'b0;

  initial begin
    bus.CH0_FULL = 1'b0;
    bus.CH1_FULL = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rand_full) begin
        bus.CH0_FULL = ($urandom_range(0, 4) == 0);
        bus.CH1_FULL = ($urandom_range(0, 4) == 0);
      end else begin
        bus.CH0_FULL = f0_req;
        bus.CH1_FULL = f1_req;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [63:0] w);
    int budget = 0;
    bus.DIN = w;
    bus.iVALID = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (!bus.oREADY && budget < 200);
    if (!bus.oREADY) check("ready_timeout", bus.oREADY, 1);
    @(posedge clk); #1;
    bus.iVALID = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    int k;
    w = {$urandom, $urandom};
    k = $urandom_range(0, 99);
    if (k < 15) begin
      w[63:57] = 7'h7F;
    end else if (k < 35) begin
      w[63:62] = 2'b11;
      w[57] = 1'b0;
      w[4:0] = 5'h0F;
    end
    return w;
  endfunction

  initial begin
    bus.DIN = '0;
    bus.iVALID = 1'b0;
    @(posedge clk); #1;
    idle(2);
    check("rst_ch0_dout", bus.CH0_DOUT, RST_WORD);
    check("rst_ready", bus.oREADY, 0);
    rst = 1'b0;
    idle(1);

    // Frame to CH1, back to back
    send(64'hFF00_0000_0000_0100);
    send(64'h0000_0000_0000_00A1);
    send(64'h0000_0000_0000_00A2);
    send(64'hC000_0000_0000_00EF);
    idle(2);
    check("frame_ch1_last", bus.CH1_DOUT, 64'hC000_0000_0000_00EF);

    // Orphan data word
    do_reset();
    send(64'h1234);
    idle(2);
    check("orphan_cnt", bus.HEADER_LOST_CNT, 1);

    // Lost footer: CH0 frame interrupted by a CH1 header
    do_reset();
    send(64'hFF00_0000_0000_0000);
    send(64'h0000_0000_5555_0000);
    send(64'hFE00_0000_0000_0100);
    idle(3);
    check("lost_ftr_cnt", bus.FOOTER_LOST_CNT, 1);
    check("lost_ftr_ch0", bus.CH0_DOUT, FOOT);
    check("lost_ftr_ch1", bus.CH1_DOUT, 64'hFE00_0000_0000_0100);

    // Backpressure mid-frame on CH0
    do_reset();
    send(64'hFF00_0000_0000_0000);
    send(64'h0000_0000_0000_0B01);
    f0_req = 1'b1;
    idle(2);
    bus.DIN = 64'h0000_0000_0000_0B02;
    bus.iVALID = 1'b1;
    idle(3);
    f0_req = 1'b0;
    send(64'h0000_0000_0000_0B02);
    send(64'hC000_0000_0000_00EF);
    idle(2);

    // Reset mid-frame then a fresh CH0 frame
    send(64'hFF00_0000_0000_0000);
    send(64'h0000_0000_0000_0D01);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(64'hFF00_0000_0000_0000);
    send(64'h0000_0000_0000_0D02);
    send(64'hC000_0000_0000_00EF);
    idle(2);
    check("rst_frame_hl", bus.HEADER_LOST_CNT, 0);
    check("rst_frame_fl", bus.FOOTER_LOST_CNT, 0);

    // Random traffic with random backpressure
    do_reset();
    rand_full = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(rand_word());
    end
    rand_full = 1'b0;
    idle(10);

    // Header-lost counter saturation
    do_reset();
    bus.DIN = 64'h1234;
    bus.iVALID = 1'b1;
    idle(65540);
    bus.iVALID = 1'b0;
    idle(2);
    check("hl_saturate", bus.HEADER_LOST_CNT, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
